// File: rtl/ternary_matrix_loader.sv
// Collects M packed ternary weight rows and one activation vector from two
// valid/ready streams, then offers them as one transaction to ternary_matmul.
module ternary_matrix_loader #(
  parameter int N         = 4,
  parameter int M         = 4,
  parameter int DataWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N*DataWidth-1:0] vec_i,
  input  logic                   vec_valid_i,
  output logic                   vec_ready_o,
  input  logic [N*2-1:0]         row_i,
  input  logic                   row_valid_i,
  output logic                   row_ready_o,
  output logic [N*DataWidth-1:0] vector_o,
  output logic [M*N*2-1:0]       matrix_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   err_o
);

  localparam int CW = $clog2(M + 1);
  localparam logic [CW-1:0] MCNT = CW'(M);

  typedef enum logic {LOAD, ISSUE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          row_cnt_q, row_cnt_d;
  logic                   vec_have_q, vec_have_d;
  logic [N*DataWidth-1:0] vector_q, vector_d;
  logic [M*N*2-1:0]       matrix_q, matrix_d;
  logic                   err_q, err_d;
  logic                   row_fire, vec_fire;

  // Code 2'b10 has no ternary meaning; it is replaced by zero weight.
  function automatic logic [N*2-1:0] sanitize_row(input logic [N*2-1:0] row);
    logic [N*2-1:0] res;
    res = row;
    for (int c = 0; c < N; c++) begin
      if (row[c*2 +: 2] == 2'b10) res[c*2 +: 2] = 2'b00;
    end
    return res;
  endfunction

  function automatic logic row_illegal(input logic [N*2-1:0] row);
    logic ill;
    ill = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (row[c*2 +: 2] == 2'b10) ill = 1'b1;
    end
    return ill;
  endfunction

  assign row_ready_o = rst_ni && (state_q == LOAD) && (row_cnt_q < MCNT);
  assign vec_ready_o = rst_ni && (state_q == LOAD) && !vec_have_q;
  assign row_fire    = row_valid_i && row_ready_o;
  assign vec_fire    = vec_valid_i && vec_ready_o;

  assign out_valid_o = (state_q == ISSUE);
  assign vector_o    = vector_q;
  assign matrix_o    = matrix_q;
  assign err_o       = err_q;

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    vec_have_d = vec_have_q;
    vector_d   = vector_q;
    matrix_d   = matrix_q;
    err_d      = err_q;
    unique case (state_q)
      LOAD: begin
        if (row_fire) begin
          for (int r = 0; r < M; r++) begin
            if (row_cnt_q == CW'(r)) matrix_d[r*N*2 +: N*2] = sanitize_row(row_i);
          end
          row_cnt_d = row_cnt_q + CW'(1);
          err_d     = err_q | row_illegal(row_i);
        end
        if (vec_fire) begin
          vector_d   = vec_i;
          vec_have_d = 1'b1;
        end
        // Look at the post-accept counts so valid rises right after the last beat.
        if ((row_cnt_d == MCNT) && vec_have_d) state_d = ISSUE;
      end
      ISSUE: begin
        if (out_ready_i) begin
          state_d    = LOAD;
          row_cnt_d  = '0;
          vec_have_d = 1'b0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= LOAD;
      row_cnt_q  <= '0;
      vec_have_q <= 1'b0;
      vector_q   <= '0;
      matrix_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      vec_have_q <= vec_have_d;
      vector_q   <= vector_d;
      matrix_q   <= matrix_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ternary_matrix_loader.sv
// Directed and randomized bench for ternary_matrix_loader against a transaction-level model.
module tb_ternary_matrix_loader;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [N*DW-1:0]   vec_i;
  logic              vec_valid_i;
  logic              vec_ready_o;
  logic [N*2-1:0]    row_i;
  logic              row_valid_i;
  logic              row_ready_o;
  logic [N*DW-1:0]   vector_o;
  logic [M*N*2-1:0]  matrix_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              err_o;

  ternary_matrix_loader #(.N(N), .M(M), .DataWidth(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .vec_i       (vec_i),
    .vec_valid_i (vec_valid_i),
    .vec_ready_o (vec_ready_o),
    .row_i       (row_i),
    .row_valid_i (row_valid_i),
    .row_ready_o (row_ready_o),
    .vector_o    (vector_o),
    .matrix_o    (matrix_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_ov  = -1;
  int pulses   = 0;
  bit b2b_on   = 0;

  // Transaction-level reference: rows gathered so far, vector held, issue pending.
  int               m_cnt   = 0;
  bit               m_vec   = 0;
  bit               m_issue = 0;
  bit               m_err   = 0;
  logic [M*N*2-1:0] m_mat   = '0;
  logic [N*DW-1:0]  m_vecd  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tern_val(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 99;
    endcase
  endfunction

  function automatic logic [1:0] tern_enc(input int v);
    if (v == 1)  return 2'b01;
    if (v == -1) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [N*2-1:0] legal_row();
    logic [N*2-1:0] r;
    for (int c = 0; c < N; c++) r[c*2 +: 2] = tern_enc(int'($urandom_range(0, 2)) - 1);
    return r;
  endfunction

  task automatic cycle();
    bit rr, vr;
    int v;
    #1;
    rr = rst_ni && !m_issue && (m_cnt < M);
    vr = rst_ni && !m_issue && !m_vec;
    chk("row_ready", row_ready_o, rr);
    chk("vec_ready", vec_ready_o, vr);
    chk("out_valid", out_valid_o, m_issue);
    chk("err", err_o, m_err);
    chk("matrix", matrix_o, m_mat);
    chk("vector", vector_o, m_vecd);
    if (b2b_on && m_issue) begin
      if (last_ov >= 0) chk("b2b_period", cyc - last_ov, M + 1);
      last_ov = cyc;
      pulses++;
    end
    @(posedge clk);
    if (!rst_ni) begin
      m_cnt = 0; m_vec = 0; m_issue = 0; m_err = 0; m_mat = '0; m_vecd = '0;
    end else if (m_issue) begin
      if (out_ready_i) begin
        m_issue = 0; m_cnt = 0; m_vec = 0;
      end
    end else begin
      if (row_valid_i && rr) begin
        for (int c = 0; c < N; c++) begin
          v = tern_val(row_i[c*2 +: 2]);
          if (v == 99) m_err = 1;
          m_mat[m_cnt*N*2 + c*2 +: 2] = tern_enc(v);
        end
        m_cnt++;
      end
      if (vec_valid_i && vr) begin
        m_vecd = vec_i;
        m_vec  = 1;
      end
      if (m_cnt == M && m_vec) m_issue = 1;
    end
    cyc++;
    #1;
  endtask

  task automatic load_clean();
    row_valid_i = 1; vec_valid_i = 1; vec_i = $urandom;
    for (int i = 0; i < M; i++) begin
      row_i = legal_row();
      cycle();
      vec_valid_i = 0;
    end
    row_valid_i = 0;
  endtask

  initial begin
    rst_ni = 0; vec_i = '0; vec_valid_i = 0; row_i = '0; row_valid_i = 0; out_ready_i = 1;
    @(posedge clk); #1;
    repeat (2) cycle();
    chk("reset_matrix", matrix_o, 0);
    rst_ni = 1;

    // Basic transaction
    row_valid_i = 1; row_i = 8'h55; vec_valid_i = 1; vec_i = 32'h04030201;
    cycle();
    vec_valid_i = 0;
    repeat (3) cycle();
    row_valid_i = 0;
    chk("basic_valid", out_valid_o, 1);
    chk("basic_matrix", matrix_o, 32'h5555_5555);
    chk("basic_vector", vector_o, 32'h04030201);
    cycle();

    // Illegal code, then a clean transaction keeps err set
    row_valid_i = 1; row_i = 8'b10_01_11_00; vec_valid_i = 1; vec_i = $urandom;
    cycle();
    vec_valid_i = 0;
    chk("err_rise", err_o, 1);
    row_i = 8'h00; cycle();
    row_i = 8'hff; cycle();
    row_i = 8'h41; cycle();
    row_valid_i = 0;
    chk("illegal_store", matrix_o[7:0], 8'b00_01_11_00);
    cycle();
    load_clean();
    chk("err_sticky", err_o, 1);
    cycle();

    // Backpressure with beats pending upstream
    out_ready_i = 0;
    load_clean();
    row_valid_i = 1; vec_valid_i = 1; row_i = 8'h11; vec_i = 32'hdeadbeef;
    repeat (5) cycle();
    chk("bp_row_ready", row_ready_o, 0);
    out_ready_i = 1;
    cycle();
    cycle();
    vec_valid_i = 0;
    repeat (3) cycle();
    row_valid_i = 0;
    chk("bp_pending_vec", vector_o, 32'hdeadbeef);
    chk("bp_pending_mat", matrix_o, 32'h1111_1111);
    cycle();

    // Late vector
    row_valid_i = 1;
    for (int i = 0; i < M; i++) begin row_i = legal_row(); cycle(); end
    row_valid_i = 0;
    repeat (3) cycle();
    chk("late_row_ready", row_ready_o, 0);
    vec_valid_i = 1; vec_i = $urandom;
    cycle();
    vec_valid_i = 0;
    chk("late_valid", out_valid_o, 1);
    cycle();

    // Reset mid-load
    row_valid_i = 1;
    repeat (2) begin row_i = legal_row(); cycle(); end
    row_valid_i = 0; rst_ni = 0;
    cycle();
    rst_ni = 1;
    chk("midrst_matrix", matrix_o, 0);
    chk("midrst_err", err_o, 0);
    load_clean();
    cycle();

    // Back-to-back streaming
    b2b_on = 1; row_valid_i = 1; vec_valid_i = 1; out_ready_i = 1;
    repeat (20) begin
      row_i = legal_row(); vec_i = $urandom;
      cycle();
    end
    b2b_on = 0;
    chk("b2b_pulses", pulses, 4);

    // Randomized traffic
    repeat (400) begin
      rst_ni      = ($urandom_range(0, 59) != 0);
      row_valid_i = $urandom_range(0, 1);
      vec_valid_i = $urandom_range(0, 1);
      out_ready_i = $urandom_range(0, 1);
      row_i       = ($urandom_range(0, 7) == 0) ? N*2'($urandom) : legal_row();
      vec_i       = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
